// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - Multi-digit 7-segment scanner with frame-aligned double buffering and leading-zero blanking
module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    digit_blank,
    output logic                    frame_tick,
    output logic                    load_pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_valid;

    logic                    tick;
    logic                    boundary;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [4*NUM_DIGITS-1:0] active_nxt;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    zero_run;
    logic [3:0]              code_nxt;
    logic [NUM_DIGITS-1:0]   sel_nxt;
    logic                    blank_nxt;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign cnt_nxt  = tick ? '0 : cnt + 1'b1;

    always_comb begin
        idx_nxt = idx;
        if (tick) begin
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    // A load landing exactly on the boundary bypasses the pending buffer.
    always_comb begin
        active_nxt = active;
        if (boundary) begin
            if (load) begin
                active_nxt = value;
            end else if (pend_valid) begin
                active_nxt = pending;
            end
        end
    end

    // zero_from[k] = nibbles k..NUM_DIGITS-1 of the next active value are all zero.
    always_comb begin
        zero_run  = 1'b1;
        zero_from = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (active_nxt[4*k +: 4] == 4'h0);
            zero_from[k] = zero_run;
        end
    end

    // Outputs are registered from next-state so they line up with idx/active.
    always_comb begin
        code_nxt  = '0;
        sel_nxt   = '0;
        blank_nxt = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                code_nxt   = active_nxt[4*k +: 4];
                sel_nxt[k] = 1'b1;
                blank_nxt  = blank_lz && (k != 0) && zero_from[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            active       <= '0;
            pending      <= '0;
            pend_valid   <= 1'b0;
            digit_code   <= 4'h0;
            digit_sel    <= NUM_DIGITS'(1);
            digit_blank  <= 1'b0;
            frame_tick   <= 1'b0;
            load_pending <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            active <= active_nxt;
            if (load && !boundary) begin
                pending      <= value;
                pend_valid   <= 1'b1;
                load_pending <= 1'b1;
            end else if (boundary) begin
                pend_valid   <= 1'b0;
                load_pending <= 1'b0;
            end
            digit_code  <= code_nxt;
            digit_sel   <= sel_nxt;
            digit_blank <= blank_nxt;
            frame_tick  <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - Directed bench for seg_scan_mux with SCAN_DIV=4, NUM_DIGITS=4
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        digit_blank;
    logic        frame_tick;
    logic        load_pending;

    int total = 0;
    int bad   = 0;

    seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .value        (value),
        .blank_lz     (blank_lz),
        .digit_code   (digit_code),
        .digit_sel    (digit_sel),
        .digit_blank  (digit_blank),
        .frame_tick   (frame_tick),
        .load_pending (load_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        blz;
        logic [15:0] codes;
        logic [3:0]  blanks;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", {15'd0, frame_tick}, 16'd1);
    endtask

    // Called at the frame_tick cycle; walks one whole frame.
    task automatic check_frame(input logic [15:0] codes, input logic [3:0] blanks);
        logic [3:0] sel_e;
        for (int d = 0; d < 4; d++) begin
            sel_e = 4'b0001 << d;
            for (int c = 0; c < 4; c++) begin
                chk("sel", {12'd0, digit_sel}, {12'd0, sel_e});
                chk("code", {12'd0, digit_code}, {12'd0, codes[4*d +: 4]});
                chk("blank", {15'd0, digit_blank}, {15'd0, blanks[d]});
                chk("frame_tick", {15'd0, frame_tick}, {15'd0, (d == 0 && c == 0)});
                chk("pending_idle", {15'd0, load_pending}, 16'd0);
                @(negedge clk);
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sel", {12'd0, digit_sel}, 16'h0001);
        chk("rst_code", {12'd0, digit_code}, 16'h0000);
        chk("rst_blank", {15'd0, digit_blank}, 16'h0000);
        chk("rst_tick", {15'd0, frame_tick}, 16'h0000);
        chk("rst_pending", {15'd0, load_pending}, 16'h0000);
    endtask

    initial begin
        logic [15:0] scan_val;
        logic [3:0]  sel_e;

        vecs[0] = '{val: 16'h1234, blz: 1'b0, codes: 16'h1234, blanks: 4'b0000};
        vecs[1] = '{val: 16'h0050, blz: 1'b1, codes: 16'h0050, blanks: 4'b1100};
        vecs[2] = '{val: 16'h0000, blz: 1'b1, codes: 16'h0000, blanks: 4'b1110};
        vecs[3] = '{val: 16'h0050, blz: 1'b0, codes: 16'h0050, blanks: 4'b0000};
        vecs[4] = '{val: 16'hABCD, blz: 1'b1, codes: 16'hABCD, blanks: 4'b0000};
        vecs[5] = '{val: 16'h0100, blz: 1'b1, codes: 16'h0100, blanks: 4'b1000};
        vecs[6] = '{val: 16'hF000, blz: 1'b1, codes: 16'hF000, blanks: 4'b0000};

        rst_n = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();

        // Scan order: load 0x1234 at cycle 2, first swap at boundary cycle 15.
        rst_n = 1'b1;
        scan_val = 16'h1234;
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (cyc < 16) begin
                sel_e = 4'b0001 << (cyc / 4);
                chk("init_sel", {12'd0, digit_sel}, {12'd0, sel_e});
                chk("init_code", {12'd0, digit_code}, 16'h0000);
                chk("init_tick", {15'd0, frame_tick}, 16'h0000);
            end else begin
                sel_e = 4'b0001 << ((cyc / 4) % 4);
                chk("scan_sel", {12'd0, digit_sel}, {12'd0, sel_e});
                chk("scan_code", {12'd0, digit_code}, {12'd0, scan_val[4*((cyc/4)%4) +: 4]});
                chk("scan_tick", {15'd0, frame_tick}, {15'd0, (cyc % 16 == 0)});
            end
            if (cyc <= 2 || cyc >= 16)
                chk("scan_pend0", {15'd0, load_pending}, 16'h0000);
            else if (cyc >= 4)
                chk("scan_pend1", {15'd0, load_pending}, 16'h0001);
            if (cyc == 2) begin load = 1'b1; value = 16'h1234; end
            if (cyc == 3) load = 1'b0;
            @(negedge clk);
        end

        foreach (vecs[i]) begin
            blank_lz = vecs[i].blz;
            load = 1'b1; value = vecs[i].val;
            @(negedge clk);
            load = 1'b0;
            wait_frame();
            check_frame(vecs[i].codes, vecs[i].blanks);
        end

        // Latest wins: 0x1111 overwritten by 0x2222 within the same frame.
        blank_lz = 1'b0;
        load = 1'b1; value = 16'h1111;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        load = 1'b1; value = 16'h2222;
        @(negedge clk); load = 1'b0;
        chk("lw_pending", {15'd0, load_pending}, 16'h0001);
        wait_frame();
        check_frame(16'h2222, 4'b0000);

        // Load exactly in the boundary cycle bypasses pending.
        for (int c = 0; c < 15; c++) begin
            chk("bnd_pend_pre", {15'd0, load_pending}, 16'h0000);
            @(negedge clk);
        end
        chk("bnd_sel", {12'd0, digit_sel}, 16'h0008);
        load = 1'b1; value = 16'h5678;
        @(negedge clk); load = 1'b0;
        check_frame(16'h5678, 4'b0000);

        // Asynchronous reset at idx=2 with a pending value.
        repeat (8) @(negedge clk);
        chk("mid_sel", {12'd0, digit_sel}, 16'h0004);
        load = 1'b1; value = 16'h9999;
        @(negedge clk); load = 1'b0;
        chk("mid_pending", {15'd0, load_pending}, 16'h0001);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 17; cyc++) begin
            sel_e = 4'b0001 << ((cyc / 4) % 4);
            chk("post_sel", {12'd0, digit_sel}, {12'd0, sel_e});
            chk("post_code", {12'd0, digit_code}, 16'h0000);
            chk("post_tick", {15'd0, frame_tick}, {15'd0, (cyc == 16)});
            chk("post_pend", {15'd0, load_pending}, 16'h0000);
            chk("post_blank", {15'd0, digit_blank}, {15'd0, (cyc >= 6 && (cyc / 4) % 4 != 0)});
            if (cyc == 5) blank_lz = 1'b1;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
